keypad_emulator: RTL and testbench
==================================

// Module: keypad_emulator
// PURPOSE
//  Drives the four keypad row lines (filas) the way a physical 4x4 keypad would, given
//  key codes from a valid/ready request port. Watches the scanning column strobes and asserts
//  the row of the requested key only while that key's column is strobed.
//  Used as a keypad stand-in on-board (scripted input) and in lab benches in front of the scanner.
// PARAMETERS
//  HOLD_CYCLES   2_700_000  cycles a key stays pressed (100 ms @ 27 MHz); must be >= 1
//  GAP_CYCLES    1_350_000  released cycles after each key before key_ready returns; must be >= 1
//  BOUNCE_TOGGLES  4        make/break edges per bounce burst (only with KEYPAD_BOUNCE_EN)
//  BOUNCE_PERIOD   2_700    cycles between bounce edges (only with KEYPAD_BOUNCE_EN)
// PORTS
//  clk        in   1  system clock (27 MHz)
//  reset      in   1  synchronous, active-high reset
//  key_code   in   4  key to press: same code map as the scanner output (0-9, A-E); F = pause
//  key_valid  in   1  request valid; key_code must be held stable while valid && !key_ready
//  key_ready  out  1  high only in IDLE; transfer when key_valid && key_ready at posedge clk
//  columnas   in   4  one-hot column strobe from the scanner, active high
//  filas      out  4  row lines, active high, one-hot or zero; registered
//  busy       out  1  high from the accept cycle until return to IDLE
// BEHAVIOUR
//  Clock/reset: one clock, clk. reset is synchronous and active-high.
//  Reset: state=IDLE; filas=0; key_ready=1 from the first cycle after reset; busy=0; counters=0.
//  Reset mid-press: filas=0 on the next edge. The in-flight key is dropped.
//  Key map (col one-hot, row one-hot): 1:(1000,1000) 2:(0100,1000) 3:(0010,1000) A:(0001,1000)
//   4:(1000,0100) 5:(0100,0100) 6:(0010,0100) B:(0001,0100) 7:(1000,0010) 8:(0100,0010)
//   9:(0010,0010) C:(0001,0010) D:(1000,0001) 0:(0100,0001) E:(0010,0001).
//  FSM
//   IDLE -> PRESS on accept: latch col/row; hold counter=0.
//   PRESS: counts HOLD_CYCLES cycles -> GAP.
//   GAP: filas=0; counts GAP_CYCLES cycles -> IDLE.
//   Code F: accepted, goes PRESS->GAP with the row drive forced off (pure pause).
//  Row drive
//   filas <= (state==PRESS && |(columnas & col_q)) ? row_q : 4'b0.
//   Latency is one clk from columnas to filas.
//   columnas that is 0 or not one-hot gives filas=0, unless the key's column bit is set.
//  Timing
//   key_ready drops the cycle after accept.
//   Accept to IDLE is exactly HOLD_CYCLES+GAP_CYCLES+1 cycles (+bounce, see CONFIGURATION).
//   Back-to-back requests are allowed: the next accept can happen on the first IDLE cycle.
//  Counters: width $clog2(max(HOLD_CYCLES,GAP_CYCLES,BOUNCE_PERIOD)+1). Terminal compare
//   is ==N-1, then cleared. No wrap occurs while a state is active.
//  key_valid with key_ready low: ignored, no state change. Sender must hold the request.
// CONFIGURATION
//  KEYPAD_BOUNCE_EN defined:
//   - Extra states BOUNCE_IN (before PRESS) and BOUNCE_OUT (before GAP).
//   - In each, the row-drive enable toggles every BOUNCE_PERIOD cycles for BOUNCE_TOGGLES edges.
//   - BOUNCE_IN starts enabled; BOUNCE_OUT starts disabled.
//   - Each state lasts BOUNCE_TOGGLES*BOUNCE_PERIOD cycles.
//   - Code F stays silent in these states as well.
//  KEYPAD_BOUNCE_EN undefined: the bounce states, logic and parameters' effect are absent.
//   Edges are clean.
// STRUCTURE
//  keypad_pkg: typedef key_code_t (logic[3:0]); enum emu_state_t
//   {IDLE,BOUNCE_IN,PRESS,BOUNCE_OUT,GAP};
//   functions key_to_col/key_to_row (the map above; F -> 4'b0000);
//   constant KEY_PAUSE=4'hF. The scanner decode shares the same package.
//  Sub-module keypad_bounce_gen (only under KEYPAD_BOUNCE_EN): start/done pulse interface.
//   It toggles enable every BOUNCE_PERIOD cycles, BOUNCE_TOGGLES times.
// TESTING (HOLD_CYCLES=20, GAP_CYCLES=10, BOUNCE_PERIOD=3, BOUNCE_TOGGLES=4 in bench)
//  1 Reset, then key_code=5, valid 1 cycle:
//    filas=0100 one cycle after each columnas=0100, 0 for other columns.
//    key_ready back after 31 cycles.
//  2 Key A with the columnas scan running: filas=1000 only while columnas=0001.
//    Scanner sample==4'hA.
//  3 Sequence 1,2,3 with key_valid held high: three presses, no lost or duplicated key.
//    Each accept lands on the first IDLE cycle.
//  4 Code F: filas stays 0 for the whole 31 cycles; busy=1 throughout.
//  5 reset pulsed mid-PRESS for key 8: filas=0 next cycle; key_ready=1 after release.
//    No residual press.
//  6 KEYPAD_BOUNCE_EN, key 0, columnas held 0100:
//    filas toggles 0001/0000 every 3 cycles (4 edges), then stable 20 cycles,
//    then a 4-edge release burst, then 0.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: key code type, emulator states and the key -> column/row map
// shared by the keypad emulator and the scanner decode.
package keypad_pkg;

  typedef logic [3:0] key_code_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    BOUNCE_IN  = 3'd1,
    PRESS      = 3'd2,
    BOUNCE_OUT = 3'd3,
    GAP        = 3'd4
  } emu_state_t;

  localparam key_code_t KEY_PAUSE = 4'hF;

  // Column strobe (one-hot) that reaches the given key; pause maps to none.
  function automatic logic [3:0] key_to_col(input key_code_t k);
    logic [3:0] c;
    case (k)
      4'h1, 4'h4, 4'h7, 4'hD: c = 4'b1000;
      4'h2, 4'h5, 4'h8, 4'h0: c = 4'b0100;
      4'h3, 4'h6, 4'h9, 4'hE: c = 4'b0010;
      4'hA, 4'hB, 4'hC:       c = 4'b0001;
      default:                c = 4'b0000;
    endcase
    return c;
  endfunction

  // Row line (one-hot) the given key shorts to its column; pause maps to none.
  function automatic logic [3:0] key_to_row(input key_code_t k);
    logic [3:0] r;
    case (k)
      4'h1, 4'h2, 4'h3, 4'hA: r = 4'b1000;
      4'h4, 4'h5, 4'h6, 4'hB: r = 4'b0100;
      4'h7, 4'h8, 4'h9, 4'hC: r = 4'b0010;
      4'hD, 4'h0, 4'hE:       r = 4'b0001;
      default:                r = 4'b0000;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/keypad_bounce_gen.sv
// keypad_bounce_gen: contact-bounce enable generator. A start pulse loads the
// initial enable level; the enable then toggles every PERIOD cycles, TOGGLES
// times, and done pulses in the last cycle of the burst.
// Only instantiated when KEYPAD_BOUNCE_EN is defined.
module keypad_bounce_gen #(
  parameter int TOGGLES = 4,
  parameter int PERIOD  = 2700
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic start_level,
  output logic en,
  output logic done
);

  localparam int PW = $clog2(PERIOD + 1);
  localparam int TW = $clog2(TOGGLES + 1);

  logic          active_r;
  logic          en_r;
  logic [PW-1:0] per_r;
  logic [TW-1:0] tog_r;
  logic          edge_s;
  logic          last_s;

  assign edge_s = active_r && (per_r == PW'(PERIOD - 1));
  assign last_s = edge_s && (tog_r == TW'(TOGGLES - 1));
  assign en     = en_r;
  assign done   = last_s;

  // Period counter and toggle counter driving the enable level.
  always_ff @(posedge clk) begin
    if (reset) begin
      active_r <= 1'b0;
      en_r     <= 1'b0;
      per_r    <= '0;
      tog_r    <= '0;
    end else if (start) begin
      active_r <= 1'b1;
      en_r     <= start_level;
      per_r    <= '0;
      tog_r    <= '0;
    end else if (edge_s) begin
      active_r <= !last_s;
      en_r     <= !en_r;
      per_r    <= '0;
      tog_r    <= tog_r + TW'(1);
    end else if (active_r) begin
      per_r    <= per_r + PW'(1);
    end
  end

endmodule

// File: rtl/keypad_emulator.sv
// keypad_emulator: drives the 4 row lines of a virtual 4x4 keypad for key codes
// taken from a valid/ready port, asserting the key's row only while its column
// is strobed. Optional contact bounce around each press: define KEYPAD_BOUNCE_EN.
module keypad_emulator
  import keypad_pkg::*;
#(
  parameter int HOLD_CYCLES    = 2_700_000,
  parameter int GAP_CYCLES     = 1_350_000,
  parameter int BOUNCE_TOGGLES = 4,
  parameter int BOUNCE_PERIOD  = 2_700
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] key_code,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [3:0] columnas,
  output logic [3:0] filas,
  output logic       busy
);

  localparam int MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAX_C  = (MAX_HG > BOUNCE_PERIOD) ? MAX_HG : BOUNCE_PERIOD;
  localparam int CW     = $clog2(MAX_C + 1);

  emu_state_t    state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic [3:0]    col_r, row_r, filas_r;
  logic          key_ready_r, busy_r;
  logic          accept_s, drive_s;
  logic          bounce_start_s, bounce_level_s;

`ifdef KEYPAD_BOUNCE_EN
  logic bounce_en_s, bounce_done_s;

  keypad_bounce_gen #(
    .TOGGLES (BOUNCE_TOGGLES),
    .PERIOD  (BOUNCE_PERIOD)
  ) u_bounce (
    .clk         (clk),
    .reset       (reset),
    .start       (bounce_start_s),
    .start_level (bounce_level_s),
    .en          (bounce_en_s),
    .done        (bounce_done_s)
  );

  assign drive_s = (state_r == PRESS) ||
                   (((state_r == BOUNCE_IN) || (state_r == BOUNCE_OUT)) && bounce_en_s);
`else
  assign drive_s = (state_r == PRESS);
`endif

  assign accept_s  = key_valid && key_ready_r;
  assign key_ready = key_ready_r;
  assign busy      = busy_r;
  assign filas     = filas_r;

  // Next-state and phase counter: idle -> (bounce in) -> press -> (bounce out) -> gap.
  always_comb begin
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    bounce_start_s = 1'b0;
    bounce_level_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          cnt_nxt_s      = '0;
`ifdef KEYPAD_BOUNCE_EN
          state_nxt_s    = BOUNCE_IN;
          bounce_start_s = 1'b1;
          bounce_level_s = 1'b1;
`else
          state_nxt_s    = PRESS;
`endif
        end else begin
          state_nxt_s = IDLE;
        end
      end
`ifdef KEYPAD_BOUNCE_EN
      BOUNCE_IN: begin
        if (bounce_done_s) begin
          state_nxt_s = PRESS;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = BOUNCE_IN;
        end
      end
      BOUNCE_OUT: begin
        if (bounce_done_s) begin
          state_nxt_s = GAP;
          cnt_nxt_s   = '0;
        end else begin
          state_nxt_s = BOUNCE_OUT;
        end
      end
`endif
      PRESS: begin
        if (cnt_r == CW'(HOLD_CYCLES - 1)) begin
          cnt_nxt_s      = '0;
`ifdef KEYPAD_BOUNCE_EN
          state_nxt_s    = BOUNCE_OUT;
          bounce_start_s = 1'b1;
          bounce_level_s = 1'b0;
`else
          state_nxt_s    = GAP;
`endif
        end else begin
          cnt_nxt_s = cnt_r + CW'(1);
        end
      end
      GAP: begin
        if (cnt_r == CW'(GAP_CYCLES - 1)) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
        end else begin
          cnt_nxt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // State, latched key position and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      col_r       <= 4'b0000;
      row_r       <= 4'b0000;
      filas_r     <= 4'b0000;
      key_ready_r <= 1'b1;
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      if (accept_s) begin
        col_r <= key_to_col(key_code);
        row_r <= key_to_row(key_code);
      end
      filas_r     <= (drive_s && |(columnas & col_r)) ? row_r : 4'b0000;
      key_ready_r <= (state_nxt_s == IDLE);
      busy_r      <= (state_nxt_s != IDLE);
    end
  end

endmodule

// File: tb/tb_keypad_emulator.sv
// tb_keypad_emulator: directed scenarios plus randomized traffic, checked every
// cycle against a timeline model of the keypad emulator.
module tb_keypad_emulator;
  import keypad_pkg::*;

  localparam int H  = 20;
  localparam int G  = 10;
  localparam int BP = 3;
  localparam int BT = 4;
`ifdef KEYPAD_BOUNCE_EN
  localparam int TP = BT * BP;
`else
  localparam int TP = 0;
`endif
  localparam int TOTAL = H + G + 2 * TP;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic [3:0] columnas;
  logic [3:0] filas;
  logic       busy;

  always #5 clk = ~clk;

  keypad_emulator #(
    .HOLD_CYCLES    (H),
    .GAP_CYCLES     (G),
    .BOUNCE_TOGGLES (BT),
    .BOUNCE_PERIOD  (BP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .columnas  (columnas),
    .filas     (filas),
    .busy      (busy)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  // Timeline model: busy flag, first PRESS-phase cycle index, latched key.
  bit         m_busy = 1'b0;
  int         m_acc  = 0;
  logic [3:0] m_key  = 4'h0;

  int         col_mode = 2;
  logic [3:0] col_fixed = 4'b0000;
  int         scan_idx = 0;
  logic [3:0] prev_col = 4'b0000;
  logic [3:0] req_q[$];

  // Physical keypad layout, row-major, left to right.
  logic [3:0] layout [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hD, 4'h0, 4'hE, 4'hF};

  function automatic int pos_of(input logic [3:0] k);
    for (int i = 0; i < 16; i++) if (layout[i] == k) return i;
    return 15;
  endfunction

  function automatic logic [3:0] ref_col(input logic [3:0] k);
    if (k == 4'hF) return 4'b0000;
    return 4'b1000 >> (pos_of(k) % 4);
  endfunction

  function automatic logic [3:0] ref_row(input logic [3:0] k);
    if (k == 4'hF) return 4'b0000;
    return 4'b1000 >> (pos_of(k) / 4);
  endfunction

  // Whether the key contact is closed d cycles into the press timeline.
  function automatic bit ref_drive(input int d);
    if (d < TP)               return ((d / BP) % 2) == 0;
    else if (d < TP + H)      return 1'b1;
    else if (d < 2 * TP + H)  return (((d - TP - H) / BP) % 2) == 1;
    else                      return 1'b0;
  endfunction

  // Scanner-style decode of a (row, column) pair back to a key code.
  function automatic logic [3:0] decode(input logic [3:0] r, input logic [3:0] c);
    for (int i = 0; i < 15; i++)
      if (ref_row(layout[i]) == r && ref_col(layout[i]) == c) return layout[i];
    return 4'hF;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // One clock: drive columnas, advance the model, clock, check all outputs.
  task automatic tick();
    logic [3:0] e_filas;
    case (col_mode)
      0: columnas = col_fixed;
      1: begin
        columnas = 4'b1000 >> scan_idx;
        scan_idx = (scan_idx + 1) % 4;
      end
      default: columnas = 4'($urandom_range(0, 15));
    endcase
    e_filas = 4'b0000;
    if (m_busy && ref_drive(cyc - m_acc) && ((columnas & ref_col(m_key)) != 4'b0000))
      e_filas = ref_row(m_key);
    if (reset) begin
      m_busy  = 1'b0;
      e_filas = 4'b0000;
    end else if (m_busy) begin
      if (cyc - m_acc == TOTAL - 1) m_busy = 1'b0;
    end else if (key_valid) begin
      m_busy = 1'b1;
      m_acc  = cyc + 1;
      m_key  = key_code;
    end
    prev_col = columnas;
    @(posedge clk);
    #1;
    cyc++;
    check("filas", 32'(filas), 32'(e_filas));
    check("key_ready", 32'(key_ready), 32'(!m_busy));
    check("busy", 32'(busy), 32'(m_busy));
  endtask

  // Offer each queued key, holding valid until it is taken.
  task automatic send_queue(output int nticks);
    bit taken;
    nticks = 0;
    while (req_q.size() != 0 && nticks < 2000) begin
      key_valid = 1'b1;
      key_code  = req_q[0];
      taken     = key_ready;
      tick();
      nticks++;
      if (taken) void'(req_q.pop_front());
    end
    key_valid = 1'b0;
    key_code  = 4'($urandom_range(0, 15));
    check("send_done", 32'(req_q.size()), 32'd0);
    req_q.delete();
  endtask

  task automatic run_until_ready();
    int n = 0;
    while (key_ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("idle_reached", 32'(key_ready), 32'd1);
  endtask

  initial begin
    int n;
    int hits;
    reset = 1'b1; key_valid = 1'b0; key_code = 4'h0; columnas = 4'b0000;

    // Reset state.
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // 1: key 5 with valid for one cycle, scanning columns.
    col_mode = 1;
    key_valid = 1'b1; key_code = 4'h5;
    tick();
    n = 1;
    key_valid = 1'b0; key_code = 4'h3;
    while (key_ready !== 1'b1 && n < 300) begin
      tick();
      n++;
    end
    check("ready_latency", 32'(n), 32'(TOTAL + 1));

    // 2: key A under a running scan, decoded like the scanner would.
    req_q.push_back(4'hA);
    send_queue(n);
    hits = 0;
    for (int i = 0; i < TOTAL + 2; i++) begin
      tick();
      if (filas !== 4'b0000) begin
        hits++;
        check("scan_sample", 32'(decode(filas, prev_col)), 32'hA);
      end
    end
    check("scan_hits_seen", 32'(hits != 0), 32'd1);
    run_until_ready();

    // 3: 1,2,3 back-to-back with valid held high.
    req_q.push_back(4'h1); req_q.push_back(4'h2); req_q.push_back(4'h3);
    send_queue(n);
    check("b2b_accept_ticks", 32'(n), 32'(2 * TOTAL + 3));
    run_until_ready();

    // 4: pause code, random column activity.
    col_mode = 2;
    req_q.push_back(KEY_PAUSE);
    send_queue(n);
    run_until_ready();

    // 5: reset in the middle of the press of key 8.
    col_mode = 1;
    req_q.push_back(4'h8);
    send_queue(n);
    repeat (TP + 8) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("ready_after_reset", 32'(key_ready), 32'd1);
    repeat (TOTAL + 5) tick();

`ifdef KEYPAD_BOUNCE_EN
    // 6: key 0 with its column held, bounce bursts around the press.
    col_mode = 0; col_fixed = 4'b0100;
    req_q.push_back(4'h0);
    send_queue(n);
    run_until_ready();
    repeat (3) tick();
`endif

    // Randomized traffic: keys, idle gaps, column patterns, occasional resets.
    for (int it = 0; it < 80; it++) begin
      col_mode  = int'($urandom_range(0, 2));
      col_fixed = ($urandom_range(0, 1) == 0) ? (4'b1000 >> $urandom_range(0, 3))
                                              : 4'($urandom_range(0, 15));
      repeat ($urandom_range(0, 3)) begin
        key_code = 4'($urandom_range(0, 15));
        tick();
      end
      req_q.push_back(4'($urandom_range(0, 15)));
      if ($urandom_range(0, 2) == 0) req_q.push_back(4'($urandom_range(0, 15)));
      send_queue(n);
      if ($urandom_range(0, 9) == 0) begin
        repeat ($urandom_range(0, TOTAL)) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
      end
    end
    run_until_ready();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
